// File: rtl/lsu_bus_master.sv
// Load/store unit bus initiator: turns byte/half/word core requests into
// word-aligned single-cycle bus reads/writes, with read-modify-write for sub-word stores.
module lsu_bus_master #(
    parameter bit FAULT_ON_UNSELECTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    output logic [31:0] resp_read_data,
    output logic        resp_misaligned,
    output logic        resp_access_fault,
    output logic        bus_active,
    output logic        bus_rw,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_selected,
    input  logic        bus_interrupted
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t              state_q, state_d;

    logic                write_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic [WORD_W-1:0]   address_q;
    logic [HALF_W-1:0]   store_lo_q;
    logic                latch_en;

    logic                req_ready_d;
    logic                resp_valid_d;
    logic [WORD_W-1:0]   resp_read_data_d;
    logic                resp_misaligned_d;
    logic                resp_access_fault_d;
    logic                bus_active_d;
    logic                bus_rw_d;
    logic [WORD_W-1:0]   bus_address_d;
    logic [WORD_W-1:0]   bus_write_data_d;

    logic                req_misaligned;
    logic                bus_fault;
    logic [BYTE_W-1:0]   lane_byte;
    logic [HALF_W-1:0]   lane_half;
    logic [WORD_W-1:0]   load_ext;
    logic [WORD_W-1:0]   merged_word;

    // Alignment of the incoming request; size 11 never aligns.
    always_comb begin
        case (req_size)
            SIZE_BYTE: req_misaligned = 1'b0;
            SIZE_HALF: req_misaligned = req_address[0];
            SIZE_WORD: req_misaligned = |req_address[1:0];
            default:   req_misaligned = 1'b1;
        endcase
    end

    assign bus_fault = bus_interrupted || (!bus_selected && FAULT_ON_UNSELECTED);

    // Lane extraction/extension for loads and lane merge for sub-word stores.
    always_comb begin
        case (address_q[1:0])
            2'd0:    lane_byte = bus_read_data[7:0];
            2'd1:    lane_byte = bus_read_data[15:8];
            2'd2:    lane_byte = bus_read_data[23:16];
            default: lane_byte = bus_read_data[31:24];
        endcase
        lane_half = address_q[1] ? bus_read_data[31:16] : bus_read_data[15:0];

        case (size_q)
            SIZE_BYTE: load_ext = {{(WORD_W-BYTE_W){!unsigned_q && lane_byte[BYTE_W-1]}}, lane_byte};
            SIZE_HALF: load_ext = {{(WORD_W-HALF_W){!unsigned_q && lane_half[HALF_W-1]}}, lane_half};
            default:   load_ext = bus_read_data;
        endcase

        merged_word = bus_read_data;
        if (size_q == SIZE_BYTE) begin
            case (address_q[1:0])
                2'd0:    merged_word[7:0]   = store_lo_q[7:0];
                2'd1:    merged_word[15:8]  = store_lo_q[7:0];
                2'd2:    merged_word[23:16] = store_lo_q[7:0];
                default: merged_word[31:24] = store_lo_q[7:0];
            endcase
        end else if (address_q[1]) begin
            merged_word[31:16] = store_lo_q;
        end else begin
            merged_word[15:0] = store_lo_q;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d             = state_q;
        latch_en            = 1'b0;
        req_ready_d         = 1'b0;
        resp_valid_d        = 1'b0;
        resp_read_data_d    = '0;
        resp_misaligned_d   = 1'b0;
        resp_access_fault_d = 1'b0;
        bus_active_d        = 1'b0;
        bus_rw_d            = 1'b0;
        bus_address_d       = '0;
        bus_write_data_d    = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    latch_en = 1'b1;
                    if (req_misaligned) begin
                        state_d           = RESP;
                        resp_valid_d      = 1'b1;
                        resp_misaligned_d = 1'b1;
                    end else if (req_write && req_size == SIZE_WORD) begin
                        state_d          = WRITE;
                        bus_active_d     = 1'b1;
                        bus_rw_d         = 1'b1;
                        bus_address_d    = {req_address[31:2], 2'b00};
                        bus_write_data_d = req_write_data;
                    end else begin
                        state_d       = READ;
                        bus_active_d  = 1'b1;
                        bus_address_d = {req_address[31:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            READ: begin
                if (bus_fault) begin
                    state_d             = RESP;
                    resp_valid_d        = 1'b1;
                    resp_access_fault_d = 1'b1;
                end else if (!write_q) begin
                    state_d          = RESP;
                    resp_valid_d     = 1'b1;
                    resp_read_data_d = bus_selected ? load_ext : '0;
                end else if (!bus_selected) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d          = WRITE;
                    bus_active_d     = 1'b1;
                    bus_rw_d         = 1'b1;
                    bus_address_d    = {address_q[31:2], 2'b00};
                    bus_write_data_d = merged_word;
                end
            end
            WRITE: begin
                state_d             = RESP;
                resp_valid_d        = 1'b1;
                resp_access_fault_d = bus_fault;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_read_data    <= '0;
            resp_misaligned   <= 1'b0;
            resp_access_fault <= 1'b0;
            bus_active        <= 1'b0;
            bus_rw            <= 1'b0;
            bus_address       <= '0;
            bus_write_data    <= '0;
            write_q           <= 1'b0;
            size_q            <= '0;
            unsigned_q        <= 1'b0;
            address_q         <= '0;
            store_lo_q        <= '0;
        end else begin
            state_q           <= state_d;
            req_ready         <= req_ready_d;
            resp_valid        <= resp_valid_d;
            resp_read_data    <= resp_read_data_d;
            resp_misaligned   <= resp_misaligned_d;
            resp_access_fault <= resp_access_fault_d;
            bus_active        <= bus_active_d;
            bus_rw            <= bus_rw_d;
            bus_address       <= bus_address_d;
            bus_write_data    <= bus_write_data_d;
            if (latch_en) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                address_q  <= req_address;
                store_lo_q <= req_write_data[HALF_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed vector table, reset-in-flight sequence and
// random requests against a word-memory reference model; a second instance sees only unmapped space.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_address, req_write_data;

    logic        req_ready, resp_valid, resp_misaligned, resp_access_fault;
    logic [31:0] resp_read_data;
    logic        bus_active, bus_rw;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic        bus_selected, bus_interrupted;

    logic        req_ready_nf, resp_valid_nf, resp_misaligned_nf, resp_access_fault_nf;
    logic [31:0] resp_read_data_nf;
    logic        bus_active_nf, bus_rw_nf;
    logic [31:0] bus_address_nf, bus_write_data_nf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.FAULT_ON_UNSELECTED(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_read_data(resp_read_data),
        .resp_misaligned(resp_misaligned), .resp_access_fault(resp_access_fault),
        .bus_active(bus_active), .bus_rw(bus_rw), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data),
        .bus_selected(bus_selected), .bus_interrupted(bus_interrupted)
    );

    lsu_bus_master #(.FAULT_ON_UNSELECTED(1'b0)) u_dut_nf (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_nf), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_write_data(req_write_data),
        .resp_valid(resp_valid_nf), .resp_read_data(resp_read_data_nf),
        .resp_misaligned(resp_misaligned_nf), .resp_access_fault(resp_access_fault_nf),
        .bus_active(bus_active_nf), .bus_rw(bus_rw_nf), .bus_address(bus_address_nf),
        .bus_write_data(bus_write_data_nf), .bus_read_data(32'hA5A5_A5A5),
        .bus_selected(1'b0), .bus_interrupted(1'b0)
    );

    // Slave side: 64-word RAM at 0x80000000, a faulting device at 0x40000000.
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        mem_init_done = 1'b0;
    logic        sel_mem, sel_intr;

    assign sel_mem         = bus_address[31:8] == 24'h80_0000;
    assign sel_intr        = bus_address[31:8] == 24'h40_0000;
    assign bus_selected    = sel_mem || sel_intr;
    assign bus_interrupted = sel_intr;
    assign bus_read_data   = sel_mem ? mem[bus_address[7:2]] : (sel_intr ? 32'hBAD0_BAD0 : 32'hFFFF_FFFF);

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h9E37_79B9;
            mem_init_done <= 1'b1;
        end else if (bus_active && bus_rw && sel_mem) begin
            mem[bus_address[7:2]] <= bus_write_data;
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wword;
        logic [31:0] new_word;
        logic        mapped;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] data;
        logic        mis;
        logic        fault;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word memory plus byte-lane arithmetic.
    function automatic exp_t predict(input logic w, input logic [1:0] sz, input logic u,
                                     input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] old, mask;
        int unsigned v, sh;
        e.data = 0; e.mis = 0; e.fault = 0; e.lat = 0; e.nrd = 0; e.nwr = 0; e.wword = 0;
        e.mapped   = (a[31:8] == 24'h80_0000);
        old        = e.mapped ? ref_mem[a[7:2]] : 32'h0;
        e.new_word = old;
        e.mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        if (e.mis) begin
            e.lat = 1;
            return e;
        end
        e.fault = !e.mapped;
        sh = 32'(a[1:0]) * 8;
        if (!w) begin
            e.lat = 2; e.nrd = 1;
            if (!e.fault) begin
                if (sz == 2'd0) begin
                    v = (old >> sh) & 32'hFF;
                    if (!u && v >= 128) v = v - 32'd256;
                end else if (sz == 2'd1) begin
                    v = (old >> sh) & 32'hFFFF;
                    if (!u && v >= 32768) v = v - 32'd65536;
                end else begin
                    v = old;
                end
                e.data = v;
            end
        end else if (sz == 2'd2) begin
            e.lat = 2; e.nwr = 1; e.wword = wd;
            if (!e.fault) e.new_word = wd;
        end else begin
            e.nrd = 1;
            if (e.fault) begin
                e.lat = 2;
            end else begin
                mask       = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                e.new_word = (old & ~(mask << sh)) | ((wd & mask) << sh);
                e.wword    = e.new_word;
                e.lat      = 3;
                e.nwr      = 1;
            end
        end
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        int          waited, lat1, lat0, nresp1, nresp0, nrd, nwr;
        logic [31:0] d1, d0, lastwd;
        logic        m1, f1, m0, f0, leak, badbus;
        waited = 0;
        @(negedge clk);
        while (!(req_ready && req_ready_nf) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " ready"}, 32'(req_ready && req_ready_nf), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_address = a; req_write_data = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat1 = 0; lat0 = 0; nresp1 = 0; nresp0 = 0; nrd = 0; nwr = 0;
        d1 = 0; d0 = 0; m1 = 0; f1 = 0; m0 = 0; f0 = 0; lastwd = 0; leak = 0; badbus = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                nresp1++;
                if (lat1 == 0) begin
                    lat1 = k; d1 = resp_read_data; m1 = resp_misaligned; f1 = resp_access_fault;
                end
            end else if (resp_read_data != 0 || resp_misaligned || resp_access_fault) leak = 1'b1;
            if (resp_valid_nf) begin
                nresp0++;
                if (lat0 == 0) begin
                    lat0 = k; d0 = resp_read_data_nf; m0 = resp_misaligned_nf; f0 = resp_access_fault_nf;
                end
            end else if (resp_read_data_nf != 0 || resp_misaligned_nf || resp_access_fault_nf) leak = 1'b1;
            if (bus_active) begin
                if (bus_address != {a[31:2], 2'b00}) badbus = 1'b1;
                if (bus_rw) begin
                    nwr++;
                    lastwd = bus_write_data;
                end else nrd++;
            end else if (bus_rw || bus_address != 0 || bus_write_data != 0) badbus = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat1), 32'(e.lat));
        chk({tag, " resp_count"}, 32'(nresp1), 32'd1);
        chk({tag, " read_data"}, d1, e.data);
        chk({tag, " misaligned"}, 32'(m1), 32'(e.mis));
        chk({tag, " access_fault"}, 32'(f1), 32'(e.fault));
        chk({tag, " bus_reads"}, 32'(nrd), 32'(e.nrd));
        chk({tag, " bus_writes"}, 32'(nwr), 32'(e.nwr));
        chk({tag, " idle_zero"}, 32'(leak || badbus), 32'd0);
        if (e.nwr > 0) chk({tag, " write_data"}, lastwd, e.wword);
        if (e.mapped) chk({tag, " mem_word"}, mem[a[7:2]], e.new_word);
        chk({tag, " nf_latency"}, 32'(lat0), e.mis ? 32'd1 : 32'd2);
        chk({tag, " nf_resp_count"}, 32'(nresp0), 32'd1);
        chk({tag, " nf_flags_data"}, {d0[29:0], m0, f0}, {30'd0, e.mis, 1'b0});
        if (e.mapped) ref_mem[a[7:2]] = e.new_word;
    endtask

    vec_t tbl [18];

    initial begin
        exp_t        e;
        logic        w, u;
        logic [1:0]  sz;
        logic [31:0] a, wd, r;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 2};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'h12F4_5678, 32'h0000_0000, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0012, 32'h0,         32'hFFFF_FFF4, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0012, 32'h0,         32'h0000_00F4, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 1'b0, 2};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_ABCD, 32'h0000_0000, 1'b0, 1'b0, 3};
        tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'hABCD_3344, 1'b0, 1'b0, 2};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0006, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 32'h8000_0010, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 2};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 2};
        tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h8000_0010, 32'h0,         32'h0000_3344, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0,         32'hFFFF_ABCD, 1'b0, 1'b0, 2};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h8000_0013, 32'h0000_007E, 32'h0000_0000, 1'b0, 1'b0, 3};
        tbl[15] = '{1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         32'h7ECD_3344, 1'b0, 1'b0, 2};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 32'h4000_0000, 32'h0,         32'h0000_0000, 1'b0, 1'b1, 2};
        tbl[17] = '{1'b1, 2'd0, 1'b0, 32'h4000_0001, 32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 2};

        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_address = 32'h0; req_write_data = 32'h0;

        // Everything is zero while reset is held, ready follows one edge after release.
        #12;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset resp", {resp_read_data[28:0], resp_valid, resp_misaligned, resp_access_fault}, 32'd0);
        chk("reset bus_ctl", {30'd0, bus_active, bus_rw}, 32'd0);
        chk("reset bus_address", bus_address, 32'd0);
        chk("reset bus_write_data", bus_write_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 18; i++) begin
            e       = predict(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd);
            e.data  = tbl[i].data;
            e.mis   = tbl[i].mis;
            e.fault = tbl[i].fault;
            e.lat   = tbl[i].lat;
            run_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, e);
        end

        // Reset during the READ cycle of a half store: no write, no response.
        e = predict(1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h1122_3344);
        run_txn("rst_preload", 1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h1122_3344, e);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_address = 32'h8000_0022; req_write_data = 32'h0000_ABCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst in READ", {30'd0, bus_active, bus_rw}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst async bus_ctl", {30'd0, bus_active, bus_rw}, 32'd0);
        chk("rst async resp_valid", 32'(resp_valid), 32'd0);
        chk("rst async req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst release req_ready", 32'(req_ready), 32'd1);
        chk("rst no resp", 32'(resp_valid), 32'd0);
        chk("rst mem unchanged", mem[8], 32'h1122_3344);

        for (int n = 0; n < 200; n++) begin
            r  = $urandom;
            w  = r[0];
            u  = r[1];
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 32'h0000_1000 | {24'd0, r[15:8]};
                1:       a = 32'h4000_0000 | {24'd0, r[15:8]};
                default: a = 32'h8000_0000 | {24'd0, r[15:8]};
            endcase
            if (r[2]) a[1:0] = (sz == 2'd2) ? 2'd0 : (sz == 2'd1 ? {a[1], 1'b0} : a[1:0]);
            wd = $urandom;
            e  = predict(w, sz, u, a, wd);
            run_txn($sformatf("rnd%0d", n), w, sz, u, a, wd, e);
        end

        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                checks++;
                errors++;
                $display("FAIL final mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
            end else begin
                checks++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
